// File: rtl/psum_accumulator_pkg.sv
// Shared defaults and helpers for the partial-sum accumulator slice.
package psum_accumulator_pkg;

  localparam int unsigned DEF_ARRAY_DIM  = 16;
  localparam int unsigned DEF_ACC_WIDTH  = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 10;

  // Extract lane idx from a packed beat at the default geometry.
  function automatic logic [DEF_ACC_WIDTH-1:0] lane_of(
    input logic [DEF_ARRAY_DIM*DEF_ACC_WIDTH-1:0] vec,
    input int unsigned                            idx
  );
    return vec[idx*DEF_ACC_WIDTH +: DEF_ACC_WIDTH];
  endfunction

endpackage

// File: rtl/psum_lane_add.sv
// Lane-wise modular adder; on a first pass the stored value is ignored.
module psum_lane_add
  import psum_accumulator_pkg::*;
#(
  parameter int unsigned LANES = DEF_ARRAY_DIM,
  parameter int unsigned WIDTH = DEF_ACC_WIDTH
) (
  input  logic                   first,
  input  logic [LANES*WIDTH-1:0] old_data,
  input  logic [LANES*WIDTH-1:0] add_data,
  output logic [LANES*WIDTH-1:0] sum_data
);

  // Per-lane add, wrapping modulo 2^WIDTH.
  always_comb begin
    sum_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sum_data[i*WIDTH +: WIDTH] = first ? add_data[i*WIDTH +: WIDTH]
                                         : old_data[i*WIDTH +: WIDTH] + add_data[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Read-modify-write controller between PE array columns and the psum buffer.
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int unsigned ARRAY_DIM  = DEF_ARRAY_DIM,
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDR_WIDTH-1:0]         in_addr,
  input  logic [ARRAY_DIM*ACC_WIDTH-1:0] in_data,
  input  logic                          in_first,
  input  logic                          in_last,
  output logic [ADDR_WIDTH-1:0]         buf_raddr,
  input  logic [ARRAY_DIM*ACC_WIDTH-1:0] buf_rdata,
  output logic [ADDR_WIDTH-1:0]         buf_waddr,
  output logic [ARRAY_DIM*ACC_WIDTH-1:0] buf_wdata,
  output logic                          buf_wen,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDR_WIDTH-1:0]         out_addr,
  output logic [ARRAY_DIM*ACC_WIDTH-1:0] out_data
);

  localparam int unsigned DW = ARRAY_DIM * ACC_WIDTH;

  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_first_q, s1_first_d;
  logic                  s1_last_q,  s1_last_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q,  s1_addr_d;
  logic [DW-1:0]         s1_data_q,  s1_data_d;
  logic                  fwd_valid_q, fwd_valid_d;
  logic [ADDR_WIDTH-1:0] fwd_addr_q,  fwd_addr_d;
  logic [DW-1:0]         fwd_data_q,  fwd_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] out_addr_q,  out_addr_d;
  logic [DW-1:0]         out_data_q,  out_data_d;

  logic          stall;
  logic          fwd_hit;
  logic [DW-1:0] old_data;
  logic [DW-1:0] sum_data;

  psum_lane_add #(
    .LANES(ARRAY_DIM),
    .WIDTH(ACC_WIDTH)
  ) u_lane_add (
    .first   (s1_first_q),
    .old_data(old_data),
    .add_data(s1_data_q),
    .sum_data(sum_data)
  );

  // Stall/forward decode, buffer port drive and next-state for all stages.
  // The forward register holds (rather than clears) across a stall so a
  // stalled beat keeps seeing the write issued just before it.
  always_comb begin
    stall    = s1_valid_q && s1_last_q && out_valid_q && !out_ready;
    fwd_hit  = fwd_valid_q && (fwd_addr_q == s1_addr_q);
    old_data = fwd_hit ? fwd_data_q : buf_rdata;

    in_ready  = !stall;
    buf_raddr = stall ? s1_addr_q : in_addr;
    buf_wen   = s1_valid_q && !stall;
    buf_waddr = s1_addr_q;
    buf_wdata = sum_data;

    s1_valid_d  = s1_valid_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s1_addr_d   = s1_addr_q;
    s1_data_d   = s1_data_q;
    fwd_valid_d = fwd_valid_q;
    fwd_addr_d  = fwd_addr_q;
    fwd_data_d  = fwd_data_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;

    if (!stall) begin
      s1_valid_d  = in_valid;
      s1_first_d  = in_first;
      s1_last_d   = in_last;
      s1_addr_d   = in_addr;
      s1_data_d   = in_data;
      fwd_valid_d = s1_valid_q;
      fwd_addr_d  = s1_addr_q;
      fwd_data_d  = sum_data;
    end

    if (s1_valid_q && s1_last_q && !stall) begin
      out_valid_d = 1'b1;
      out_addr_d  = s1_addr_q;
      out_data_d  = sum_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control and output registers, cleared by async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      fwd_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      fwd_valid_q <= fwd_valid_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

  // Datapath registers, qualified by their valid bits so no reset is needed.
  always_ff @(posedge clk) begin
    s1_first_q <= s1_first_d;
    s1_last_q  <= s1_last_d;
    s1_addr_q  <= s1_addr_d;
    s1_data_q  <= s1_data_d;
    fwd_addr_q <= fwd_addr_d;
    fwd_data_q <= fwd_data_d;
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed table-driven bench for psum_accumulator with a behavioural buffer.
module tb_psum_accumulator;
  import psum_accumulator_pkg::*;

  localparam int unsigned AD = DEF_ARRAY_DIM;
  localparam int unsigned AW = DEF_ACC_WIDTH;
  localparam int unsigned RW = DEF_ADDR_WIDTH;
  localparam int unsigned DW = AD * AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_first, in_last;
  logic [RW-1:0] in_addr, buf_raddr, buf_waddr, out_addr;
  logic [DW-1:0] in_data, buf_rdata, buf_wdata, out_data;
  logic          buf_wen, out_valid, out_ready;

  logic [DW-1:0] mem [0:(1<<RW)-1];

  int errors = 0;
  int checks = 0;

  psum_accumulator #(
    .ARRAY_DIM(AD),
    .ACC_WIDTH(AW),
    .ADDR_WIDTH(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
    .buf_waddr(buf_waddr), .buf_wdata(buf_wdata), .buf_wen(buf_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Buffer model: registered read, read-before-write on the same address.
  always @(posedge clk) begin
    buf_rdata <= mem[buf_raddr];
    if (buf_wen) mem[buf_waddr] <= buf_wdata;
  end

  function automatic logic [DW-1:0] mk(input logic [31:0] base, input logic [31:0] step);
    logic [DW-1:0] v;
    for (int i = 0; i < int'(AD); i++) v[i*AW +: AW] = base + step * i;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // inputs: v f l addr db ds ordy | expected: rdy wen wa wb ws ov oa ob os ra(-1 = skip)
  typedef struct {
    bit v, f, l; int addr; logic [31:0] db, ds; bit ordy;
    bit rdy, wen; int wa; logic [31:0] wb, ws;
    bit ov; int oa; logic [31:0] ob, os;
    int ra;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    tbl = '{
      // single beat first+last, addr 5, lanes 7
      '{1,1,1, 5,7,0,1,  1,0,0,0,0,  0,0,0,0,  5},
      '{0,0,0, 0,0,0,1,  1,1,5,7,0,  0,0,0,0, -1},
      '{0,0,0, 0,0,0,1,  1,0,0,0,0,  1,5,7,0, -1},
      '{0,0,0, 0,0,0,1,  1,0,0,0,0,  0,0,0,0, -1},
      // three spaced beats to addr 3: writes 1, 3, 6
      '{1,1,0, 3,1,0,1,  1,0,0,0,0,  0,0,0,0,  3},
      '{0,0,0, 0,0,0,1,  1,1,3,1,0,  0,0,0,0, -1},
      '{0,0,0, 0,0,0,1,  1,0,0,0,0,  0,0,0,0, -1},
      '{1,0,0, 3,2,0,1,  1,0,0,0,0,  0,0,0,0,  3},
      '{0,0,0, 0,0,0,1,  1,1,3,3,0,  0,0,0,0, -1},
      '{0,0,0, 0,0,0,1,  1,0,0,0,0,  0,0,0,0, -1},
      '{1,0,1, 3,3,0,1,  1,0,0,0,0,  0,0,0,0,  3},
      '{0,0,0, 0,0,0,1,  1,1,3,6,0,  0,0,0,0, -1},
      '{0,0,0, 0,0,0,1,  1,0,0,0,0,  1,3,6,0, -1},
      '{0,0,0, 0,0,0,1,  1,0,0,0,0,  0,0,0,0, -1},
      // back-to-back addr 9, lane i = i, four beats -> lane i = 4*i
      '{1,1,0, 9,0,1,1,  1,0,0,0,0,  0,0,0,0,  9},
      '{1,0,0, 9,0,1,1,  1,1,9,0,1,  0,0,0,0,  9},
      '{1,0,0, 9,0,1,1,  1,1,9,0,2,  0,0,0,0,  9},
      '{1,0,1, 9,0,1,1,  1,1,9,0,3,  0,0,0,0,  9},
      '{0,0,0, 0,0,0,1,  1,1,9,0,4,  0,0,0,0, -1},
      '{0,0,0, 0,0,0,1,  1,0,0,0,0,  1,9,0,4, -1},
      '{0,0,0, 0,0,0,1,  1,0,0,0,0,  0,0,0,0, -1},
      // overflow: 0xFFFFFFFF + 2 wraps to 1
      '{1,1,0, 20,32'hFFFFFFFF,0,1,  1,0,0,0,0,  0,0,0,0, 20},
      '{0,0,0, 0,0,0,1,  1,1,20,32'hFFFFFFFF,0,  0,0,0,0, -1},
      '{1,0,0, 20,2,0,1, 1,0,0,0,0,  0,0,0,0, 20},
      '{0,0,0, 0,0,0,1,  1,1,20,1,0, 0,0,0,0, -1},
      '{0,0,0, 0,0,0,1,  1,0,0,0,0,  0,0,0,0, -1},
      // backpressure: second last beat stalls behind undelivered result
      '{1,1,1, 40,10,0,0, 1,0,0,0,0,   0,0,0,0,   40},
      '{1,1,1, 41,20,0,0, 1,1,40,10,0, 0,0,0,0,   41},
      '{1,1,1, 42,30,0,0, 0,0,0,0,0,   1,40,10,0, 41},
      '{1,1,1, 42,30,0,0, 0,0,0,0,0,   1,40,10,0, 41},
      '{1,1,1, 42,30,0,1, 1,1,41,20,0, 1,40,10,0, 42},
      '{0,0,0, 0,0,0,1,   1,1,42,30,0, 1,41,20,0, -1},
      '{0,0,0, 0,0,0,1,   1,0,0,0,0,   1,42,30,0, -1},
      '{0,0,0, 0,0,0,1,   1,0,0,0,0,   0,0,0,0,   -1}
    };

    rst_n = 1'b0; in_valid = 0; in_first = 0; in_last = 0;
    in_addr = '0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset buf_wen",   buf_wen,   0);
    chk("reset out_data",  out_data,  0);
    chk("reset out_addr",  out_addr,  0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      in_valid  = tbl[i].v;
      in_first  = tbl[i].f;
      in_last   = tbl[i].l;
      in_addr   = tbl[i].addr[RW-1:0];
      in_data   = mk(tbl[i].db, tbl[i].ds);
      out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("c%0d in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("c%0d buf_wen", i),  buf_wen,  tbl[i].wen);
      if (tbl[i].wen) begin
        chk($sformatf("c%0d buf_waddr", i), buf_waddr, tbl[i].wa);
        chk($sformatf("c%0d buf_wdata", i), buf_wdata, mk(tbl[i].wb, tbl[i].ws));
      end
      chk($sformatf("c%0d out_valid", i), out_valid, tbl[i].ov);
      if (tbl[i].ov) begin
        chk($sformatf("c%0d out_addr", i), out_addr, tbl[i].oa);
        chk($sformatf("c%0d out_data", i), out_data, mk(tbl[i].ob, tbl[i].os));
      end
      if (tbl[i].ra >= 0) chk($sformatf("c%0d buf_raddr", i), buf_raddr, tbl[i].ra);
      @(posedge clk);
      #1;
    end

    chk("mem[3]",  mem[3],  mk(6, 0));
    chk("mem[9]",  mem[9],  mk(0, 4));
    chk("mem[9] lane15", lane_of(mem[9], 15), 60);
    chk("mem[20]", mem[20], mk(1, 0));
    chk("mem[40]", mem[40], mk(10, 0));
    chk("mem[41]", mem[41], mk(20, 0));
    chk("mem[42]", mem[42], mk(30, 0));

    // Async reset with S1 and output register both occupied.
    in_valid = 1; in_first = 1; in_last = 1; in_addr = 50; in_data = mk(5, 0); out_ready = 0;
    @(posedge clk); #1;
    in_addr = 51; in_data = mk(6, 0);
    @(posedge clk); #1;
    in_valid = 0;
    chk("pre-reset out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", out_valid, 0);
    chk("async reset buf_wen",   buf_wen,   0);
    chk("async reset out_data",  out_data,  0);
    chk("async reset in_ready",  in_ready,  1);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1;
    in_valid = 1; in_first = 1; in_last = 0; in_addr = 50; in_data = mk(3, 0);
    @(negedge clk);
    chk("restart c0 buf_wen", buf_wen, 0);
    @(posedge clk); #1;
    in_first = 0; in_last = 1; in_data = mk(4, 0);
    @(negedge clk);
    chk("restart c1 buf_wen",   buf_wen,   1);
    chk("restart c1 buf_wdata", buf_wdata, mk(3, 0));
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
    @(negedge clk);
    chk("restart c2 buf_wen",   buf_wen,   1);
    chk("restart c2 buf_wdata", buf_wdata, mk(7, 0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("restart out_valid", out_valid, 1);
    chk("restart out_addr",  out_addr,  50);
    chk("restart out_data",  out_data,  mk(7, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
